// File: rtl/ping_pong_pkg.sv
// Shared constants and types for the Qn*KnT result drain.
// Row geometry is derived from the multi-matmul wrapper configuration.
package ping_pong_pkg;

  localparam int WIDTH_OUT            = 8;
  localparam int CHUNK_SIZE           = 2;
  localparam int NUM_CORES_A_QN_KNT   = 1;
  localparam int NUM_CORES_B_QN_KNT   = 1;
  localparam int TOTAL_MODULES_LP_Q   = 1;
  localparam int TOTAL_INPUT_W_QN_KNT = 4;

  localparam int QKT_ROW_WIDTH = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A_QN_KNT *
                                 NUM_CORES_B_QN_KNT * TOTAL_MODULES_LP_Q;
  localparam int QKT_NUM_ROWS  = TOTAL_INPUT_W_QN_KNT;

  typedef enum logic {DRAIN_IDLE, DRAIN_STREAM} drain_state_t;

endpackage

// File: rtl/matmul_result_drain_if.sv
// Row stream from the result drain toward the scaling/softmax stage.
interface matmul_result_drain_if #(
  parameter int ROW_WIDTH = 16,
  parameter int ROW_IDX_W = 2
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [ROW_WIDTH-1:0] out_data;
  logic [ROW_IDX_W-1:0] out_row_idx;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/matmul_result_drain_result_bank.sv
// One bank of the ping-pong result store: whole-array capture, row-indexed read.
module result_bank
  import ping_pong_pkg::*;
#(
  parameter int ROW_WIDTH = QKT_ROW_WIDTH,
  parameter int NUM_ROWS  = QKT_NUM_ROWS,
  parameter int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ROW_WIDTH-1:0] wr_rows [NUM_ROWS],
  input  logic [ROW_IDX_W-1:0] rd_idx,
  output logic [ROW_WIDTH-1:0] rd_data
);

  logic [ROW_WIDTH-1:0] mem_r [NUM_ROWS];
  logic [ROW_WIDTH-1:0] rd_data_s;

  // Latch every row at once on a capture strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) mem_r[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_ROWS; i++) mem_r[i] <= wr_rows[i];
    end
  end

  // OR-reduced one-hot read mux; out-of-range indices read as zero
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      rd_data_s = rd_data_s | ((rd_idx == ROW_IDX_W'(i)) ? mem_r[i] : '0);
    end
  end

  assign rd_data = rd_data_s;

endmodule

// File: rtl/matmul_result_drain.sv
// Captures matmul result arrays into a ping-pong store and streams them row by row.
module matmul_result_drain
  import ping_pong_pkg::*;
#(
  parameter int ROW_WIDTH = QKT_ROW_WIDTH,
  parameter int NUM_ROWS  = QKT_NUM_ROWS,
  parameter int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROW_WIDTH-1:0]  in_rows [NUM_ROWS],
  input  logic                  in_capture,
  output logic                  cap_ready,
  output logic                  overflow,
  matmul_result_drain_if.master out_if
);

  drain_state_t         state_r, state_nxt_s;
  logic [1:0]           bank_full_r, bank_full_nxt_s;
  logic                 wr_bank_r, wr_bank_nxt_s;
  logic                 rd_bank_r, rd_bank_nxt_s;
  logic [ROW_IDX_W-1:0] row_idx_r, row_idx_nxt_s;
  logic                 overflow_r, overflow_nxt_s;
  logic [1:0]           bank_wr_en_s;
  logic [ROW_WIDTH-1:0] bank_rd_data_s [2];
  logic                 valid_s, last_s, handshake_s;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    result_bank #(
      .ROW_WIDTH (ROW_WIDTH),
      .NUM_ROWS  (NUM_ROWS),
      .ROW_IDX_W (ROW_IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_wr_en_s[b]),
      .wr_rows (in_rows),
      .rd_idx  (row_idx_r),
      .rd_data (bank_rd_data_s[b])
    );
  end

  assign valid_s      = (state_r == DRAIN_STREAM);
  assign last_s       = valid_s && (row_idx_r == ROW_IDX_W'(NUM_ROWS - 1));
  assign handshake_s  = valid_s && out_if.out_ready;
  assign bank_wr_en_s = (in_capture && !bank_full_r[wr_bank_r]) ?
                        (wr_bank_r ? 2'b10 : 2'b01) : 2'b00;

  // Capture bookkeeping and read FSM next-state; both use pre-update full flags
  always_comb begin
    state_nxt_s     = state_r;
    bank_full_nxt_s = bank_full_r;
    wr_bank_nxt_s   = wr_bank_r;
    rd_bank_nxt_s   = rd_bank_r;
    row_idx_nxt_s   = row_idx_r;
    overflow_nxt_s  = overflow_r;

    if (in_capture) begin
      if (bank_full_r[wr_bank_r]) begin
        overflow_nxt_s = 1'b1;
      end else begin
        bank_full_nxt_s[wr_bank_r] = 1'b1;
        wr_bank_nxt_s              = ~wr_bank_r;
      end
    end else begin
      overflow_nxt_s = overflow_r;
    end

    case (state_r)
      DRAIN_IDLE: begin
        if (bank_full_r[rd_bank_r]) begin
          state_nxt_s   = DRAIN_STREAM;
          row_idx_nxt_s = '0;
        end else begin
          state_nxt_s = DRAIN_IDLE;
        end
      end
      DRAIN_STREAM: begin
        if (handshake_s && last_s) begin
          bank_full_nxt_s[rd_bank_r] = 1'b0;
          rd_bank_nxt_s              = ~rd_bank_r;
          row_idx_nxt_s              = '0;
          state_nxt_s = bank_full_r[~rd_bank_r] ? DRAIN_STREAM : DRAIN_IDLE;
        end else if (handshake_s) begin
          row_idx_nxt_s = row_idx_r + ROW_IDX_W'(1);
        end else begin
          state_nxt_s = DRAIN_STREAM;
        end
      end
      default: begin
        state_nxt_s = DRAIN_IDLE;
      end
    endcase
  end

  // State, pointer and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= DRAIN_IDLE;
      bank_full_r <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      row_idx_r   <= '0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bank_full_r <= bank_full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      row_idx_r   <= row_idx_nxt_s;
      overflow_r  <= overflow_nxt_s;
    end
  end

  assign cap_ready          = !bank_full_r[wr_bank_r];
  assign overflow           = overflow_r;
  assign out_if.out_valid   = valid_s;
  assign out_if.out_last    = last_s;
  assign out_if.out_row_idx = row_idx_r;
  assign out_if.out_data    = valid_s ? bank_rd_data_s[rd_bank_r] : '0;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain with a row scoreboard (NUM_ROWS=4, ROW_WIDTH=16).
module tb_matmul_result_drain;

  localparam int NR = 4;
  localparam int RW = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] in_rows [NR];
  logic          in_capture;
  logic          cap_ready;
  logic          overflow;
  beat_t         sb_q [$];
  int            checks = 0;
  int            errors = 0;
  int            exp_idx;
  int            k;

  matmul_result_drain_if #(.ROW_WIDTH(RW), .ROW_IDX_W(IW)) s_if ();

  matmul_result_drain #(.ROW_WIDTH(RW), .NUM_ROWS(NR), .ROW_IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_rows    (in_rows),
    .in_capture (in_capture),
    .cap_ready  (cap_ready),
    .overflow   (overflow),
    .out_if     (s_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows(input logic [RW-1:0] base);
    for (int i = 0; i < NR; i++) in_rows[i] = base + RW'(i);
  endtask

  task automatic push_rows(input logic [RW-1:0] base);
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      b.data = base + RW'(i);
      b.idx  = IW'(i);
      b.last = (i == NR - 1);
      sb_q.push_back(b);
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (sb_q.size() == 0 && !s_if.out_valid) break;
      step();
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check("drain_idle", 32'(s_if.out_valid), 32'd0);
  endtask

  // Scoreboard: every accepted beat must match the oldest expected row
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && s_if.out_valid && s_if.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(s_if.out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("beat_data", 32'(s_if.out_data), 32'(e.data));
        check("beat_idx", 32'(s_if.out_row_idx), 32'(e.idx));
        check("beat_last", 32'(s_if.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_capture = 1'b0;
    s_if.out_ready = 1'b0;
    load_rows(16'h0000);
    step();
    step();
    rst_n = 1'b1;
    check("rst_valid", 32'(s_if.out_valid), 32'd0);
    check("rst_data", 32'(s_if.out_data), 32'd0);
    check("rst_last", 32'(s_if.out_last), 32'd0);
    check("rst_idx", 32'(s_if.out_row_idx), 32'd0);
    check("rst_cap_ready", 32'(cap_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single capture, latency and order
    s_if.out_ready = 1'b1;
    in_rows[0] = 16'h1111; in_rows[1] = 16'h2222;
    in_rows[2] = 16'h3333; in_rows[3] = 16'h4444;
    for (int i = 0; i < NR; i++) sb_q.push_back('{data: in_rows[i], idx: IW'(i), last: (i == NR - 1)});
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    check("t1_valid_n1", 32'(s_if.out_valid), 32'd0);
    check("t1_cap_ready_n1", 32'(cap_ready), 32'd1);
    step();
    check("t1_valid_n2", 32'(s_if.out_valid), 32'd1);
    check("t1_first_data", 32'(s_if.out_data), 32'h1111);
    for (int i = 0; i < NR; i++) begin
      check("t1_cap_ready", 32'(cap_ready), 32'd1);
      step();
    end
    check("t1_empty", 32'(sb_q.size()), 32'd0);
    check("t1_idle", 32'(s_if.out_valid), 32'd0);

    // Two back-to-back captures stream with no bubble
    load_rows(16'hA000); push_rows(16'hA000);
    in_capture = 1'b1;
    step();
    check("t2_cap_ready_one", 32'(cap_ready), 32'd1);
    load_rows(16'hB000); push_rows(16'hB000);
    step();
    in_capture = 1'b0;
    for (int i = 0; i < 2 * NR; i++) begin
      check("t2_no_bubble", 32'(s_if.out_valid), 32'd1);
      check("t2_cap_ready", 32'(cap_ready), (i >= NR) ? 32'd1 : 32'd0);
      step();
    end
    check("t2_empty", 32'(sb_q.size()), 32'd0);
    check("t2_idle", 32'(s_if.out_valid), 32'd0);

    // Backpressure: ready pattern 1,0,0,1
    load_rows(16'hC000); push_rows(16'hC000);
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    step();
    exp_idx = 0;
    k = 0;
    while (exp_idx < NR && k < 40) begin
      s_if.out_ready = (k % 4 == 0) || (k % 4 == 3);
      check("t3_valid", 32'(s_if.out_valid), 32'd1);
      check("t3_idx", 32'(s_if.out_row_idx), 32'(exp_idx));
      check("t3_data", 32'(s_if.out_data), 32'h0000_C000 + 32'(exp_idx));
      if (s_if.out_ready) exp_idx++;
      k++;
      step();
    end
    check("t3_all_rows", 32'(exp_idx), 32'(NR));
    s_if.out_ready = 1'b1;
    drain(20);

    // Third capture while both banks are full is dropped
    s_if.out_ready = 1'b0;
    load_rows(16'hD000); push_rows(16'hD000);
    in_capture = 1'b1;
    step();
    load_rows(16'hE000); push_rows(16'hE000);
    step();
    check("t4_cap_ready_full", 32'(cap_ready), 32'd0);
    check("t4_no_overflow_yet", 32'(overflow), 32'd0);
    load_rows(16'hF000);
    step();
    in_capture = 1'b0;
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_cap_ready_still", 32'(cap_ready), 32'd0);
    step();
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    s_if.out_ready = 1'b1;
    drain(30);
    check("t4_overflow_after", 32'(overflow), 32'd1);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_overflow", 32'(overflow), 32'd0);

    // Capture colliding with the final handshake of its target bank
    load_rows(16'h5000); push_rows(16'h5000);
    in_capture = 1'b1;
    step();
    load_rows(16'h6000); push_rows(16'h6000);
    step();
    in_capture = 1'b0;
    step();
    step();
    step();
    check("t5_last_beat", 32'(s_if.out_last), 32'd1);
    check("t5_cap_ready_low", 32'(cap_ready), 32'd0);
    load_rows(16'h7000);
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    check("t5_refused_overflow", 32'(overflow), 32'd1);
    check("t5_cap_ready_free", 32'(cap_ready), 32'd1);
    load_rows(16'h8000); push_rows(16'h8000);
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    drain(30);

    // Reset while streaming row 2
    load_rows(16'h9000); push_rows(16'h9000);
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    step();
    step();
    step();
    check("t6_idx_before", 32'(s_if.out_row_idx), 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    check("t6_valid", 32'(s_if.out_valid), 32'd0);
    check("t6_cap_ready", 32'(cap_ready), 32'd1);
    check("t6_overflow", 32'(overflow), 32'd0);
    load_rows(16'h3C00); push_rows(16'h3C00);
    in_capture = 1'b1;
    step();
    in_capture = 1'b0;
    step();
    check("t6_restart_idx", 32'(s_if.out_row_idx), 32'd0);
    check("t6_restart_data", 32'(s_if.out_data), 32'h3C00);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
